banked_stream_buffer: RTL
=========================

# banked_stream_buffer

Parametrised multi-bank sample buffer sitting between the ADC/windowing front end and the FFT core in the spectrogram pipeline. The writer streams samples sequentially into one bank at a time. Each completed bank is handed to the reader, which accesses it at random addresses (e.g. bit-reversed order) and then releases it. Bank count and depth are generic, and bank selection is by binary index.

## Interface

Parameters:
- no_banks, 8: number of banks; any value ≥ 2. Local bank_bits = $clog2(no_banks); count_bits = $clog2(no_banks+1).
- word_width, 16: sample width.
- address_width, 5: per-bank address width; depth = 2**address_width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  writer offers wr_data.
- wr_data  in  word_width  sample to store.
- wr_ready  out  1  current write bank is FREE; a write is accepted when wr_valid && wr_ready.
- wr_bank  out  bank_bits  bank currently being filled.
- rd_en  in  1  read request at rd_address in the held bank.
- rd_address  in  address_width  word address within the held bank.
- rd_release  in  1  return the held bank to FREE.
- rd_data  out  word_width  registered read data.
- rd_data_valid  out  1  rd_data updated this cycle.
- rd_bank_active  out  1  reader holds a bank.
- rd_bank  out  bank_bits  bank held or next to be acquired.
- full_count  out  count_bits  banks in FULL state.
- drop_count  out  16  saturating count of writes refused (wr_valid && !wr_ready).

## Operation

- Per-bank status: FREE, FULL, or READING. The bank at wr_bank is "filling" while FREE. Memory contents are not reset.
- Writer:
  - On accept, write wr_data at (wr_bank, wr_addr) and increment wr_addr.
  - On accepting address depth-1: wr_addr→0, status[wr_bank]→FULL, wr_bank→(wr_bank+1) mod no_banks. Wrap from no_banks-1 to 0 must work for non-power-of-two no_banks.
  - wr_ready = (status[wr_bank]==FREE), combinational from status registers.
  - Refused write: data discarded, drop_count increments and saturates at 0xFFFF.
- Reader FSM, states IDLE and ACTIVE:
  - IDLE: if status[rd_bank]==FULL → ACTIVE and status→READING.
  - ACTIVE: rd_en reads rd_address from bank rd_bank. rd_release sets status→FREE, rd_bank→(rd_bank+1) mod no_banks, state→IDLE.
  - Banks are consumed strictly in fill order. No acquire occurs in the same cycle as a release.
- rd_en while IDLE is ignored (rd_data_valid stays 0). rd_release while IDLE is ignored.
- rd_en together with rd_release: the read completes from the released bank.
- full_count counts FULL banks only, not the READING bank.
- Writer and reader never touch the same bank, so there is no read/write collision path.
- Simultaneous writer-completes-bank and reader-releases-bank (different banks) both take effect in the same edge.

## Timing

- Reset (async assert, sync-safe deassert):
  - All status FREE; wr_bank=0, wr_addr=0, rd_bank=0, state IDLE.
  - rd_data=0, rd_data_valid=0, rd_bank_active=0, full_count=0, drop_count=0.
  - wr_ready=1 in the first cycle after reset.
- Write: accepted data is in RAM after that edge, one-cycle occupancy, full throughput of 1 word/cycle.
- Last word of a bank accepted in cycle t:
  - full_count increments and wr_bank advances in cycle t+1.
  - If the reader is IDLE on that bank, rd_bank_active=1 from cycle t+2 and full_count decrements in the same cycle.
- Read latency 1: rd_en in cycle t → rd_data/rd_data_valid in cycle t+1. rd_data holds its value when not valid.
- rd_release in cycle t → rd_bank_active=0 in t+1. The bank is FREE in t+1, so wr_ready can rise in t+1 if the writer is waiting on it. The next FULL bank is acquired with rd_bank_active=1 in t+2.
- Reset asserted mid-fill or mid-read: all control returns to reset values immediately. A partially filled bank is abandoned.

## Test plan

Configuration: no_banks=4, word_width=8, address_width=3.

- Reset → all outputs 0 except wr_ready=1; rd_en pulses give no rd_data_valid.
- Write 0..7 at 1 word/cycle → wr_bank=1 and full_count=1 one cycle after last accept. rd_bank_active=1, rd_bank=0 a cycle later. rd_en addr 5 → rd_data=5, valid exactly 1 cycle later.
- Write 32 words (0..31) with rd_release never asserted → reader holds bank0, banks 1–3 FULL, full_count=3, wr_bank=0, wr_ready=0. 3 more wr_valid cycles → drop_count=3, RAM unchanged.
- From that state pulse rd_release → wr_ready=1 next cycle, rd_bank_active 0 then 1 with rd_bank=1. Read addr 0 → 8.
- no_banks=3: fill 3 banks and release each in turn → wr_bank and rd_bank wrap 2→0, and the fourth bank's data reads back correctly.
- Assert rst_n low after 4 words into bank0 → outputs at reset values asynchronously. Refill 8 words → bank0 reads back the new data only.

Source files
------------

// File: rtl/banked_stream_buffer_if.sv
// banked_stream_buffer_if: writer stream and reader bank-access signals of the banked sample buffer
interface banked_stream_buffer_if #(
  parameter int no_banks = 8,
  parameter int word_width = 16,
  parameter int address_width = 5
);
  localparam int bank_bits = $clog2(no_banks);
  localparam int count_bits = $clog2(no_banks + 1);
  logic wr_valid;
  logic [word_width-1:0] wr_data;
  logic wr_ready;
  logic [bank_bits-1:0] wr_bank;
  logic rd_en;
  logic [address_width-1:0] rd_address;
  logic rd_release;
  logic [word_width-1:0] rd_data;
  logic rd_data_valid;
  logic rd_bank_active;
  logic [bank_bits-1:0] rd_bank;
  logic [count_bits-1:0] full_count;
  logic [15:0] drop_count;
  modport master (
    output wr_valid, wr_data, rd_en, rd_address, rd_release,
    input wr_ready, wr_bank, rd_data, rd_data_valid, rd_bank_active, rd_bank, full_count, drop_count
  );
  modport slave (
    input wr_valid, wr_data, rd_en, rd_address, rd_release,
    output wr_ready, wr_bank, rd_data, rd_data_valid, rd_bank_active, rd_bank, full_count, drop_count
  );
endinterface

// File: rtl/banked_stream_buffer.sv
// banked_stream_buffer: banks filled sequentially by the writer, then handed in fill order to a random-access reader
module banked_stream_buffer #(
  parameter int no_banks = 8,
  parameter int word_width = 16,
  parameter int address_width = 5
) (
  input logic clk,
  input logic rst_n,
  banked_stream_buffer_if.slave bus
);
  localparam int bank_bits = $clog2(no_banks);
  localparam int count_bits = $clog2(no_banks + 1);
  localparam int depth = 2 ** address_width;
  typedef enum logic [1:0] {free_s, full_s, reading_s} bank_state_t;
  typedef enum logic {idle_s, active_s} rd_state_t;
  bank_state_t status [no_banks];
  rd_state_t rd_state;
  logic [word_width-1:0] mem [no_banks][depth];
  logic [bank_bits-1:0] wr_bank, rd_bank;
  logic [address_width-1:0] wr_addr;
  logic [count_bits-1:0] full_count;
  logic [15:0] drop_count;
  logic [word_width-1:0] rd_data;
  logic rd_data_valid;
  logic wr_fire, wr_last, acquire, release_bank, rd_fire;

  // explicit wrap so non-power-of-two bank counts return to bank 0
  function automatic logic [bank_bits-1:0] next_bank(input logic [bank_bits-1:0] b);
    return (b == bank_bits'(no_banks - 1)) ? '0 : b + 1'b1;
  endfunction

  assign bus.wr_ready = status[wr_bank] == free_s;
  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign wr_last = wr_fire && &wr_addr;
  assign acquire = rd_state == idle_s && status[rd_bank] == full_s;
  assign release_bank = rd_state == active_s && bus.rd_release;
  assign rd_fire = rd_state == active_s && bus.rd_en;
  assign bus.wr_bank = wr_bank;
  assign bus.rd_bank = rd_bank;
  assign bus.rd_bank_active = rd_state == active_s;
  assign bus.full_count = full_count;
  assign bus.drop_count = drop_count;
  assign bus.rd_data = rd_data;
  assign bus.rd_data_valid = rd_data_valid;

  always_ff @(posedge clk)
    if (wr_fire) mem[wr_bank][wr_addr] <= bus.wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < no_banks; i++) status[i] <= free_s;
      rd_state <= idle_s;
      wr_bank <= '0;
      rd_bank <= '0;
      wr_addr <= '0;
      full_count <= '0;
      drop_count <= '0;
      rd_data <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      if (wr_fire) wr_addr <= wr_addr + 1'b1;
      if (wr_last) begin
        status[wr_bank] <= full_s;
        wr_bank <= next_bank(wr_bank);
      end
      if (bus.wr_valid && !bus.wr_ready && drop_count != '1) drop_count <= drop_count + 1'b1;
      // writer and reader always address different banks, so both status updates may land together
      if (acquire) begin
        status[rd_bank] <= reading_s;
        rd_state <= active_s;
      end
      if (release_bank) begin
        status[rd_bank] <= free_s;
        rd_bank <= next_bank(rd_bank);
        rd_state <= idle_s;
      end
      full_count <= full_count + count_bits'(wr_last) - count_bits'(acquire);
      rd_data_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_bank][bus.rd_address];
    end
endmodule
